// File: rtl/reg_access_master_if.sv
// rtl/reg_access_master_if.sv - Command/response byte streams and register bus of reg_access_master
interface reg_access_master_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
);
   logic [7:0]            rx_data;
   logic                  rx_valid;
   logic                  rx_ready;
   logic [7:0]            tx_data;
   logic                  tx_valid;
   logic                  tx_ready;
   logic [ADDR_WIDTH-1:0] address;
   logic                  write_enable;
   logic [DATA_WIDTH-1:0] write_data;
   logic                  read_enable;
   logic [DATA_WIDTH-1:0] read_data;
   logic                  frame_error;

   modport master (
      input  rx_data, rx_valid, tx_ready, read_data,
      output rx_ready, tx_data, tx_valid, address, write_enable, write_data, read_enable, frame_error
   );

   modport slave (
      output rx_data, rx_valid, tx_ready, read_data,
      input  rx_ready, tx_data, tx_valid, address, write_enable, write_data, read_enable, frame_error
   );
endinterface

// File: rtl/reg_access_master.sv
// rtl/reg_access_master.sv - Byte-stream command decoder and register bus master
// Optional inter-byte frame timeout enabled by defining REG_MASTER_TIMEOUT_EN.
module reg_access_master #(
   parameter int ADDR_WIDTH     = 8,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                clock,
   input  logic                reset,
   reg_access_master_if.master bus
);
   localparam int         ADDR_BYTES = ADDR_WIDTH / 8;
   localparam int         DATA_BYTES = DATA_WIDTH / 8;
   localparam logic [7:0] OP_WRITE   = 8'h57;
   localparam logic [7:0] OP_READ    = 8'h52;
   localparam logic [7:0] RESP_ACK   = 8'hA5;
   localparam logic [7:0] RESP_ERR   = 8'hEE;
   localparam logic [7:0] ADDR_LAST  = 8'(ADDR_BYTES - 1);
   localparam logic [7:0] DATA_LAST  = 8'(DATA_BYTES - 1);
   localparam logic [7:0] DATA_COUNT = 8'(DATA_BYTES);

   typedef enum logic [2:0] {IDLE, ADDR, DATA, WRITE, READ, RESP} state_t;

   state_t                state;
   logic                  is_write;
   logic [7:0]            byte_cnt;
   logic [7:0]            tx_left;
   logic [ADDR_WIDTH-1:0] addr_shift;
   logic [DATA_WIDTH-1:0] data_shift;
   logic [DATA_WIDTH-1:0] tx_shift;
   logic                  rx_ready_q;
   logic                  tx_valid_q;
   logic [ADDR_WIDTH-1:0] address_q;
   logic [DATA_WIDTH-1:0] write_data_q;
   logic                  write_enable_q;
   logic                  read_enable_q;
   logic                  frame_error_q;
   logic                  accept;
   logic                  timed_out;
   logic [ADDR_WIDTH-1:0] addr_next;
   logic [DATA_WIDTH-1:0] data_next;

   assign accept    = bus.rx_valid && rx_ready_q;
   assign addr_next = ADDR_WIDTH'({addr_shift, bus.rx_data});
   assign data_next = DATA_WIDTH'({data_shift, bus.rx_data});

   assign bus.rx_ready     = rx_ready_q;
   assign bus.tx_valid     = tx_valid_q;
   assign bus.tx_data      = tx_shift[DATA_WIDTH-1 -: 8];
   assign bus.address      = address_q;
   assign bus.write_data   = write_data_q;
   assign bus.write_enable = write_enable_q;
   assign bus.read_enable  = read_enable_q;
   assign bus.frame_error  = frame_error_q;

   // Single-byte responses are left-aligned so tx_data always reads the top byte.
   function automatic logic [DATA_WIDTH-1:0] resp_word(input logic [7:0] b);
      return DATA_WIDTH'(b) << (DATA_WIDTH - 8);
   endfunction

`ifdef REG_MASTER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] idle_cnt;

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         idle_cnt <= '0;
      else if ((state == ADDR || state == DATA) && !accept)
         idle_cnt <= idle_cnt + 1'b1;
      else
         idle_cnt <= '0;
   end

   assign timed_out = (state == ADDR || state == DATA) && !accept &&
                      (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYCLES;
   assign timed_out      = 1'b0;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         is_write       <= 1'b0;
         byte_cnt       <= '0;
         tx_left        <= '0;
         addr_shift     <= '0;
         data_shift     <= '0;
         tx_shift       <= '0;
         rx_ready_q     <= 1'b0;
         tx_valid_q     <= 1'b0;
         address_q      <= '0;
         write_data_q   <= '0;
         write_enable_q <= 1'b0;
         read_enable_q  <= 1'b0;
         frame_error_q  <= 1'b0;
      end else begin
         frame_error_q <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  byte_cnt <= '0;
                  if (bus.rx_data == OP_WRITE || bus.rx_data == OP_READ) begin
                     is_write <= (bus.rx_data == OP_WRITE);
                     state    <= ADDR;
                  end else begin
                     rx_ready_q    <= 1'b0;
                     tx_shift      <= resp_word(RESP_ERR);
                     tx_left       <= 8'd1;
                     tx_valid_q    <= 1'b1;
                     frame_error_q <= 1'b1;
                     state         <= RESP;
                  end
               end else begin
                  rx_ready_q <= 1'b1;
               end
            end
            ADDR, DATA: begin
               if (timed_out) begin
                  rx_ready_q    <= 1'b0;
                  tx_shift      <= resp_word(RESP_ERR);
                  tx_left       <= 8'd1;
                  tx_valid_q    <= 1'b1;
                  frame_error_q <= 1'b1;
                  state         <= RESP;
               end else if (accept && state == ADDR) begin
                  addr_shift <= addr_next;
                  if (byte_cnt == ADDR_LAST) begin
                     byte_cnt  <= '0;
                     address_q <= addr_next;
                     if (is_write) begin
                        state <= DATA;
                     end else begin
                        rx_ready_q    <= 1'b0;
                        read_enable_q <= 1'b1;
                        state         <= READ;
                     end
                  end else begin
                     byte_cnt <= byte_cnt + 8'd1;
                  end
               end else if (accept) begin
                  data_shift <= data_next;
                  if (byte_cnt == DATA_LAST) begin
                     rx_ready_q     <= 1'b0;
                     write_data_q   <= data_next;
                     write_enable_q <= 1'b1;
                     state          <= WRITE;
                  end else begin
                     byte_cnt <= byte_cnt + 8'd1;
                  end
               end
            end
            WRITE: begin
               write_enable_q <= 1'b0;
               tx_shift       <= resp_word(RESP_ACK);
               tx_left        <= 8'd1;
               tx_valid_q     <= 1'b1;
               state          <= RESP;
            end
            READ: begin
               // read_data is combinational from the register file, valid while read_enable is high
               read_enable_q <= 1'b0;
               tx_shift      <= bus.read_data;
               tx_left       <= DATA_COUNT;
               tx_valid_q    <= 1'b1;
               state         <= RESP;
            end
            RESP: begin
               if (bus.tx_ready) begin
                  if (tx_left == 8'd1) begin
                     tx_valid_q <= 1'b0;
                     rx_ready_q <= 1'b1;
                     state      <= IDLE;
                  end else begin
                     tx_shift <= tx_shift << 8;
                     tx_left  <= tx_left - 8'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_reg_access_master.sv
// tb/tb_reg_access_master.sv - Scoreboard bench for reg_access_master
// Follows REG_MASTER_TIMEOUT_EN to choose the timeout or no-timeout scenario.
module tb_reg_access_master;
   localparam int AW = 8;
   localparam int DW = 32;
   localparam int DB = DW / 8;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   reg_access_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   reg_access_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   // Register file stand-in for controlling_register
   bit [DW-1:0] regs      [256];
   bit [DW-1:0] model_mem [256];
   assign bus.read_data = regs[bus.address];
   always @(posedge clock) if (bus.write_enable) regs[bus.address] <= bus.write_data;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int tx_pops = 0;
   int exp_err = 0;
   logic [7:0]       exp_tx [$];
   logic [AW+DW-1:0] exp_wr [$];
   logic [AW-1:0]    exp_rd [$];
   int               due_q  [$];
   bit rand_ready = 0;
   bit force_low = 0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   initial begin
      bus.tx_ready = 1'b0;
      forever begin
         @(posedge clock);
         #1;
         bus.tx_ready = force_low ? 1'b0 : (rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
      end
   end

   // Monitor / scoreboard
   bit prev_we, prev_re, prev_fe, prev_stall;
   logic [7:0] stall_data;
   always @(negedge clock) begin
      if (reset) begin
         prev_we = 0; prev_re = 0; prev_fe = 0; prev_stall = 0;
      end else begin
         if (bus.tx_valid) chk(!bus.rx_ready, "rx_ready_during_resp", bus.rx_ready, 0);
         if (bus.write_enable || bus.read_enable)
            chk(!(bus.write_enable && bus.read_enable), "strobe_overlap", 1, 0);
         if (bus.write_enable) begin
            chk(!prev_we, "we_one_cycle", 1, 0);
            if (exp_wr.size() == 0) chk(0, "unexpected_write", {bus.address, bus.write_data}, 0);
            else begin
               logic [AW+DW-1:0] w;
               w = exp_wr.pop_front();
               chk({bus.address, bus.write_data} == w, "write_bus", {bus.address, bus.write_data}, w);
            end
         end
         if (bus.read_enable) begin
            chk(!prev_re, "re_one_cycle", 1, 0);
            if (exp_rd.size() == 0) chk(0, "unexpected_read", bus.address, 0);
            else begin
               logic [AW-1:0] a;
               a = exp_rd.pop_front();
               chk(bus.address == a, "read_addr", bus.address, a);
            end
         end
         if (bus.write_enable || bus.read_enable) begin
            if (due_q.size() == 0) chk(0, "strobe_latency", cyc, 0);
            else begin
               int d;
               d = due_q.pop_front();
               chk(cyc == d, "strobe_latency", cyc, d);
            end
         end
         if (bus.frame_error) begin
            chk(!prev_fe, "frame_error_one_cycle", 1, 0);
            chk(exp_err > 0, "frame_error_expected", 1, exp_err);
            if (exp_err > 0) exp_err--;
         end
         if (prev_we || prev_re) chk(bus.tx_valid, "tx_latency", bus.tx_valid, 1);
         if (bus.tx_valid && prev_stall) chk(bus.tx_data == stall_data, "tx_stable", bus.tx_data, stall_data);
         if (bus.tx_valid && bus.tx_ready) begin
            if (exp_tx.size() == 0) chk(0, "unexpected_tx", bus.tx_data, 0);
            else begin
               logic [7:0] e;
               e = exp_tx.pop_front();
               chk(bus.tx_data == e, "tx_data", bus.tx_data, e);
            end
            tx_pops++;
         end
         prev_we    = bus.write_enable;
         prev_re    = bus.read_enable;
         prev_fe    = bus.frame_error;
         prev_stall = bus.tx_valid && !bus.tx_ready;
         stall_data = bus.tx_data;
      end
   end

   // Caller is positioned just after a rising edge; returns the cycle the byte was taken.
   task automatic send_byte(input logic [7:0] b, output int acc);
      int n = 0;
      acc = -1;
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      forever begin
         @(negedge clock);
         if (bus.rx_ready) begin
            acc = cyc;
            break;
         end
         n++;
         if (n > 300) begin
            chk(0, "rx_accept_timeout", n, 0);
            break;
         end
      end
      @(posedge clock);
      #1;
      bus.rx_valid = 1'b0;
   endtask

   task automatic send_data(input logic [DW-1:0] d, output int acc);
      for (int k = DB - 1; k >= 0; k--) send_byte(d[k*8 +: 8], acc);
   endtask

   task automatic issue_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      int acc;
      exp_wr.push_back({a, d});
      exp_tx.push_back(8'hA5);
      model_mem[a] = d;
      send_byte(8'h57, acc);
      send_byte(a, acc);
      send_data(d, acc);
      due_q.push_back(acc + 1);
   endtask

   task automatic issue_read(input logic [AW-1:0] a);
      int acc;
      logic [DW-1:0] v;
      v = model_mem[a];
      exp_rd.push_back(a);
      for (int k = DB - 1; k >= 0; k--) exp_tx.push_back(v[k*8 +: 8]);
      send_byte(8'h52, acc);
      send_byte(a, acc);
      due_q.push_back(acc + 1);
   endtask

   task automatic issue_bad(input logic [7:0] op);
      int acc;
      exp_tx.push_back(8'hEE);
      exp_err++;
      send_byte(op, acc);
   endtask

   task automatic wait_done();
      int n = 0;
      while (exp_tx.size() != 0 || exp_wr.size() != 0 || exp_rd.size() != 0 || exp_err != 0 || bus.tx_valid) begin
         @(posedge clock);
         #1;
         n++;
         if (n > 1000) begin
            chk(0, "response_timeout", exp_tx.size(), 0);
            break;
         end
      end
      @(posedge clock);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      int pops0;
      bus.rx_data  = 8'h00;
      bus.rx_valid = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk({bus.rx_ready, bus.tx_valid, bus.tx_data, bus.address, bus.write_enable,
           bus.write_data, bus.read_enable, bus.frame_error} == '0, "reset_outputs",
          {bus.tx_valid, bus.address, bus.write_data}, 0);
      @(posedge clock);
      #1;
      reset = 1'b0;

      issue_write(8'hAA, 32'h0000_1234);
      wait_done();
      issue_read(8'hAA);
      wait_done();

      // Stall the response for 10 cycles after its first byte
      pops0 = tx_pops;
      issue_read(8'hAA);
      for (int n = 0; n < 200 && tx_pops == pops0; n++) begin
         @(posedge clock);
         #1;
      end
      force_low = 1'b1;
      repeat (10) @(posedge clock);
      #1;
      force_low = 1'b0;
      wait_done();
      chk(tx_pops - pops0 == DB, "stall_byte_count", tx_pops - pops0, DB);

      issue_bad(8'h33);
      wait_done();

      // Reset in the middle of a write frame
      send_byte(8'h57, acc);
      send_byte(8'hAA, acc);
      send_byte(8'h00, acc);
      reset = 1'b1;
      @(negedge clock);
      chk({bus.rx_ready, bus.tx_valid, bus.tx_data, bus.address, bus.write_enable,
           bus.write_data, bus.read_enable, bus.frame_error} == '0, "midframe_reset_outputs",
          {bus.tx_valid, bus.address, bus.write_data}, 0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      issue_write(8'hAA, 32'hCAFE_F00D);
      wait_done();
      issue_read(8'hAA);
      wait_done();

`ifdef REG_MASTER_TIMEOUT_EN
      exp_tx.push_back(8'hEE);
      exp_err++;
      send_byte(8'h57, acc);
      begin
         int n = 0;
         forever begin
            @(negedge clock);
            if (bus.tx_valid || n > 100) break;
            n++;
         end
      end
      chk(cyc == acc + 17, "timeout_latency", cyc, acc + 17);
      @(posedge clock);
      #1;
      wait_done();
`else
      send_byte(8'h57, acc);
      repeat (100) @(posedge clock);
      #1;
      chk(!bus.tx_valid && bus.rx_ready, "no_timeout_wait", {bus.tx_valid, bus.rx_ready}, 1);
      exp_wr.push_back({8'hAA, 32'h0000_1234});
      exp_tx.push_back(8'hA5);
      model_mem[8'hAA] = 32'h0000_1234;
      send_byte(8'hAA, acc);
      send_data(32'h0000_1234, acc);
      due_q.push_back(acc + 1);
      wait_done();
`endif

      rand_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         int r;
         logic [AW-1:0] a;
         logic [7:0] op;
         r = $urandom_range(0, 9);
         a = 8'($urandom_range(0, 3) * 85);
         if (r < 5) issue_write(a, $urandom);
         else if (r < 9) issue_read(a);
         else begin
            op = 8'($urandom_range(0, 255));
            while (op == 8'h57 || op == 8'h52) op = 8'($urandom_range(0, 255));
            issue_bad(op);
         end
      end
      wait_done();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
